iq_gate_accumulator: RTL and testbench

Downstream consumer of the transmit/receive sequencer. Turns the raw echo ADC stream into one complex Doppler sample per pulse-repetition interval. During each range gate (`DEMOD_ON` high) it quadrature-samples `ADC_DATA` on the `RX_CLK` cadence and accumulates I and Q. At gate close it presents the result to the readout/FIFO stage over a valid/ready handshake.

---
 rtl/iq_gate_accumulator_pkg.sv | 20 ++
 rtl/iq_gate_accumulator_sat.sv | 47 ++++
 rtl/iq_gate_accumulator.sv | 155 +++++++++++++++
 tb/tb_iq_gate_accumulator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_gate_accumulator_pkg.sv
// rtl/iq_gate_accumulator_pkg.sv - shared encodings and helpers for the I/Q gate accumulator
package iq_gate_accumulator_pkg;

    localparam logic [1:0] freq8MHz = 2'd0;
    localparam logic [1:0] freq4MHz = 2'd1;
    localparam logic [1:0] freq2MHz = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } gate_state_t;

    // Offset-binary word of `width` bits to a sign-extended 32-bit value.
    function automatic logic signed [31:0] offset_to_signed(input logic [31:0] raw, input int width);
        logic [31:0] flipped;
        flipped = (raw ^ (32'd1 << (width - 1))) << (32 - width);
        return $signed(flipped) >>> (32 - width);
    endfunction

endpackage

// File: rtl/iq_gate_accumulator_sat.sv
// rtl/iq_gate_accumulator_sat.sv - signed saturating add/sub accumulator with sticky clip flag
module iq_sat_accumulator #(
    parameter int ACC_WIDTH = 24
) (
    input  logic                 coreClock,
    input  logic                 RESET_N,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 en,
    input  logic                 sub,
    input  logic [ACC_WIDTH-1:0] x,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 sat
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0]   sum;
    logic                 clip;
    logic [ACC_WIDTH-1:0] next_acc;

    // One guard bit: overflow shows as disagreement between the top two bits.
    always_comb begin
        sum      = sub ? ({acc[ACC_WIDTH-1], acc} - {x[ACC_WIDTH-1], x})
                       : ({acc[ACC_WIDTH-1], acc} + {x[ACC_WIDTH-1], x});
        clip     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        next_acc = clip ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge coreClock or negedge RESET_N) begin
        if (!RESET_N) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (load) begin
            acc <= x;
            sat <= 1'b0;
        end else if (en) begin
            acc <= next_acc;
            sat <= sat | clip;
        end
    end

endmodule

// File: rtl/iq_gate_accumulator.sv
// rtl/iq_gate_accumulator.sv - per-gate quadrature I/Q accumulation with valid/ready result port
module iq_gate_accumulator
    import iq_gate_accumulator_pkg::*;
#(
    parameter int ADC_WIDTH = 10,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 coreClock,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic [1:0]           freq,
    input  logic                 RX_CLK,
    input  logic                 DEMOD_ON,
    input  logic                 RETRANSMIT,
    input  logic [ADC_WIDTH-1:0] ADC_DATA,
    output logic [ACC_WIDTH-1:0] OUT_I,
    output logic [ACC_WIDTH-1:0] OUT_Q,
    output logic [CNT_WIDTH-1:0] OUT_COUNT,
    output logic [CNT_WIDTH-1:0] OUT_PRI,
    output logic                 OUT_SAT,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OVERRUN
);

    gate_state_t          state_q, state_d;
    logic                 rx_d, demod_d;
    logic [1:0]           phase;
    logic [CNT_WIDTH-1:0] count, pri;
    logic                 strobe, demod_rise, demod_fall;
    logic                 gate_open, gate_take, publish;
    logic [ACC_WIDTH-1:0] sample_x, acc_i, acc_q;
    logic                 sat_i, sat_q;

    always_comb begin
        case (freq)
            freq8MHz: strobe = 1'b1;
            freq4MHz,
            freq2MHz: strobe = RX_CLK & ~rx_d;
            default:  strobe = RX_CLK & ~rx_d;
        endcase
    end

    assign demod_rise = DEMOD_ON & ~demod_d;
    assign demod_fall = ~DEMOD_ON & demod_d;
    assign sample_x   = ACC_WIDTH'(offset_to_signed(32'(ADC_DATA), ADC_WIDTH));

    always_comb begin
        state_d   = state_q;
        gate_open = 1'b0;
        gate_take = 1'b0;
        publish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ENABLE && demod_rise) begin
                    state_d   = GATE;
                    gate_open = 1'b1;
                end
            end
            GATE: begin
                if (!ENABLE) begin
                    state_d = IDLE;
                end else if (demod_fall) begin
                    state_d = IDLE;
                    publish = 1'b1;
                end else begin
                    gate_take = strobe & DEMOD_ON;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A strobe on the opening cycle is phase 0, so I loads it directly.
    iq_sat_accumulator #(.ACC_WIDTH(ACC_WIDTH)) u_acc_i (
        .coreClock (coreClock),
        .RESET_N   (RESET_N),
        .clear     (gate_open & ~strobe),
        .load      (gate_open & strobe),
        .en        (gate_take & ~phase[0]),
        .sub       (phase[1]),
        .x         (sample_x),
        .acc       (acc_i),
        .sat       (sat_i)
    );

    iq_sat_accumulator #(.ACC_WIDTH(ACC_WIDTH)) u_acc_q (
        .coreClock (coreClock),
        .RESET_N   (RESET_N),
        .clear     (gate_open),
        .load      (1'b0),
        .en        (gate_take & phase[0]),
        .sub       (phase[1]),
        .x         (sample_x),
        .acc       (acc_q),
        .sat       (sat_q)
    );

    always_ff @(posedge coreClock or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            rx_d    <= 1'b0;
            demod_d <= 1'b0;
            phase   <= 2'd0;
            count   <= '0;
            pri     <= '0;
        end else begin
            state_q <= state_d;
            rx_d    <= RX_CLK;
            demod_d <= DEMOD_ON;
            if (gate_open) begin
                phase <= strobe ? 2'd1 : 2'd0;
                count <= CNT_WIDTH'(strobe);
            end else if (gate_take) begin
                phase <= phase + 2'd1;
                if (~&count)
                    count <= count + 1'b1;
            end
            if (!ENABLE)
                pri <= '0;
            else if (RETRANSMIT)
                pri <= pri + 1'b1;
        end
    end

    // Ready in the publish cycle consumes the old result, so no overrun.
    always_ff @(posedge coreClock or negedge RESET_N) begin
        if (!RESET_N) begin
            OUT_I     <= '0;
            OUT_Q     <= '0;
            OUT_COUNT <= '0;
            OUT_PRI   <= '0;
            OUT_SAT   <= 1'b0;
            OUT_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (!ENABLE)
                OVERRUN <= 1'b0;
            if (publish) begin
                OUT_I     <= acc_i;
                OUT_Q     <= acc_q;
                OUT_COUNT <= count;
                OUT_PRI   <= pri;
                OUT_SAT   <= sat_i | sat_q;
                OUT_VALID <= 1'b1;
                if (OUT_VALID && !OUT_READY)
                    OVERRUN <= 1'b1;
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iq_gate_accumulator.sv
// tb/tb_iq_gate_accumulator.sv - randomized self-checking bench for iq_gate_accumulator
module tb_iq_gate_accumulator;
    import iq_gate_accumulator_pkg::*;

    logic       coreClock = 1'b0;
    logic       RESET_N, ENABLE, RX_CLK, DEMOD_ON, RETRANSMIT, OUT_READY;
    logic [1:0] freq;
    logic [9:0] ADC_DATA;

    logic signed [23:0] out_i, out_q;
    logic [15:0]        out_count, out_pri;
    logic               out_sat, out_valid, overrun;
    logic signed [11:0] s_i, s_q;
    logic [15:0]        s_count, s_pri;
    logic               s_sat, s_valid, s_overrun;

    always #5 coreClock = ~coreClock;

    iq_gate_accumulator #(.ADC_WIDTH(10), .ACC_WIDTH(24), .CNT_WIDTH(16)) dut (
        .coreClock(coreClock), .RESET_N(RESET_N), .ENABLE(ENABLE), .freq(freq),
        .RX_CLK(RX_CLK), .DEMOD_ON(DEMOD_ON), .RETRANSMIT(RETRANSMIT), .ADC_DATA(ADC_DATA),
        .OUT_I(out_i), .OUT_Q(out_q), .OUT_COUNT(out_count), .OUT_PRI(out_pri),
        .OUT_SAT(out_sat), .OUT_VALID(out_valid), .OUT_READY(OUT_READY), .OVERRUN(overrun)
    );

    iq_gate_accumulator #(.ADC_WIDTH(10), .ACC_WIDTH(12), .CNT_WIDTH(16)) dut_s (
        .coreClock(coreClock), .RESET_N(RESET_N), .ENABLE(ENABLE), .freq(freq),
        .RX_CLK(RX_CLK), .DEMOD_ON(DEMOD_ON), .RETRANSMIT(RETRANSMIT), .ADC_DATA(ADC_DATA),
        .OUT_I(s_i), .OUT_Q(s_q), .OUT_COUNT(s_count), .OUT_PRI(s_pri),
        .OUT_SAT(s_sat), .OUT_VALID(s_valid), .OUT_READY(OUT_READY), .OVERRUN(s_overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: samples of the open gate plus the expected result port.
    int   samp[$];
    bit   in_gate, m_rx_d, m_dm_d;
    int   m_pri;
    bit   e_valid, e_ovr, e_sat, e_sat12;
    int   e_i, e_q, e_cnt, e_pri, e_i12, e_q12;
    logic rdy;
    logic [9:0] basic_pat [4] = '{10'h3FF, 10'h200, 10'h000, 10'h200};

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void gate_sums(input int w, output int si, output int sq, output bit sat);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        int v;
        si = 0; sq = 0; sat = 0;
        foreach (samp[k]) begin
            v = ((k % 4) < 2) ? samp[k] : -samp[k];
            if (k % 2 == 0) begin
                si += v;
                if (si > hi) begin si = hi; sat = 1; end
                else if (si < lo) begin si = lo; sat = 1; end
            end else begin
                sq += v;
                if (sq > hi) begin sq = hi; sat = 1; end
                else if (sq < lo) begin sq = lo; sat = 1; end
            end
        end
    endfunction

    task automatic cycle(input logic rx, input logic dm, input logic [9:0] adc,
                         input logic en, input logic rt, input logic rd);
        bit strobe, pub;
        RX_CLK = rx; DEMOD_ON = dm; ADC_DATA = adc; ENABLE = en; RETRANSMIT = rt; OUT_READY = rd;
        strobe = (freq == freq8MHz) || (rx && !m_rx_d);
        pub = 0;
        if (!en) begin
            in_gate = 0;
            e_ovr   = 0;
        end else if (!in_gate && dm && !m_dm_d) begin
            in_gate = 1;
            samp.delete();
            if (strobe) samp.push_back(int'(adc) - 512);
        end else if (in_gate && !dm && m_dm_d) begin
            pub = 1;
            in_gate = 0;
            gate_sums(24, e_i, e_q, e_sat);
            gate_sums(12, e_i12, e_q12, e_sat12);
            e_cnt = (samp.size() > 65535) ? 65535 : samp.size();
            e_pri = m_pri;
            if (e_valid && !rd) e_ovr = 1;
            e_valid = 1;
        end else if (in_gate && dm && strobe) begin
            samp.push_back(int'(adc) - 512);
        end
        if (!pub && e_valid && rd) e_valid = 0;
        if (!en) m_pri = 0;
        else if (rt) m_pri = (m_pri + 1) % 65536;
        m_rx_d = rx;
        m_dm_d = dm;
        @(posedge coreClock);
        @(negedge coreClock);
        check("valid", out_valid, e_valid);
        check("overrun", overrun, e_ovr);
        check("s_valid", s_valid, e_valid);
        check("s_overrun", s_overrun, e_ovr);
        if (e_valid) begin
            check("out_i", out_i, e_i);
            check("out_q", out_q, e_q);
            check("out_count", out_count, e_cnt);
            check("out_pri", out_pri, e_pri);
            check("out_sat", out_sat, e_sat);
            check("s_i", s_i, e_i12);
            check("s_q", s_q, e_q12);
            check("s_sat", s_sat, e_sat12);
            check("s_count", s_count, e_cnt);
            check("s_pri", s_pri, e_pri);
        end
    endtask

    function automatic logic [9:0] pattern(input int mode, input int idx);
        if (mode == 0) return basic_pat[idx % 4];
        if (mode == 1) return 10'h3FF;
        return 10'($urandom_range(0, 1023));
    endfunction

    // Gate whose first cycle carries an RX_CLK rise, closed after nstr strobes.
    task automatic run_gate(input int nstr, input int period, input int mode, input logic rdy_close);
        logic rx;
        repeat (2) cycle(1'b0, 1'b0, 10'h200, 1'b1, 1'b0, rdy);
        for (int c = 0; c < 2000; c++) begin
            rx = (c % period) < (period / 2);
            cycle(rx, 1'b1, pattern(mode, samp.size()), 1'b1, 1'b0, rdy);
            if (samp.size() >= nstr) break;
        end
        if (samp.size() < nstr) check("gate_timeout", samp.size(), nstr);
        cycle(1'b0, 1'b0, 10'($urandom_range(0, 1023)), 1'b1, 1'b0, rdy_close);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET_N = 0; ENABLE = 0; RX_CLK = 0; DEMOD_ON = 0; RETRANSMIT = 0;
        OUT_READY = 0; ADC_DATA = '0; freq = freq4MHz; rdy = 1;
        in_gate = 0; m_rx_d = 0; m_dm_d = 0; m_pri = 0;
        e_valid = 0; e_ovr = 0; e_sat = 0; e_sat12 = 0;
        e_i = 0; e_q = 0; e_cnt = 0; e_pri = 0; e_i12 = 0; e_q12 = 0;
        repeat (2) @(negedge coreClock);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_i", out_i, 0);
        check("rst_count", out_count, 0);
        RESET_N = 1;

        // Basic gate: 4 MHz, 16 strobes of the reference pattern.
        freq = freq4MHz;
        run_gate(16, 4, 0, 1'b1);
        check("basic_valid", out_valid, 1);
        check("basic_i", out_i, 4092);
        check("basic_q", out_q, 0);
        check("basic_count", out_count, 16);
        check("basic_sat", out_sat, 0);

        // Constant full-scale input over a 12-cycle 8 MHz gate.
        freq = freq8MHz;
        run_gate(12, 2, 1, 1'b1);
        check("const_i", out_i, 0);
        check("const_q", out_q, 0);
        check("const_count", out_count, 12);

        // Saturation on the 12-bit instance.
        freq = freq2MHz;
        run_gate(12, 3, 0, 1'b1);
        check("sat12_i", s_i, 2047);
        check("sat12_flag", s_sat, 1);
        check("sat24_flag", out_sat, 0);

        // Backpressure: overwrite, then ready in the publish cycle.
        rdy = 0;
        freq = freq4MHz;
        run_gate(8, 2, 2, 1'b0);
        run_gate(8, 2, 2, 1'b0);
        check("bp_overrun", overrun, 1);
        cycle(1'b0, 1'b0, 10'h200, 1'b0, 1'b0, 1'b0);
        run_gate(8, 4, 2, 1'b1);
        check("bp_ready_overrun", overrun, 0);
        check("bp_ready_valid", out_valid, 1);
        rdy = 1;
        cycle(1'b0, 1'b0, 10'h200, 1'b1, 1'b0, 1'b1);

        // PRI tagging.
        cycle(1'b0, 1'b0, 10'h200, 1'b0, 1'b0, 1'b1);
        for (int g = 0; g < 3; g++) begin
            run_gate(4, 2, 2, 1'b1);
            check("pri_tag", out_pri, g);
            cycle(1'b0, 1'b0, 10'h200, 1'b1, 1'b1, 1'b1);
        end

        // ENABLE drop mid-gate with a pending result and overrun set.
        rdy = 0;
        run_gate(4, 2, 2, 1'b0);
        run_gate(4, 2, 2, 1'b0);
        cycle(1'b0, 1'b0, 10'h200, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 10'h200, 1'b1, 1'b0, 1'b0);
        check("abort_overrun", overrun, 0);
        check("abort_valid", out_valid, 1);
        rdy = 1;
        cycle(1'b0, 1'b0, 10'h200, 1'b1, 1'b0, 1'b1);
        run_gate(4, 2, 2, 1'b1);
        check("abort_pri", out_pri, 0);

        // Asynchronous reset mid-gate with a result pending.
        rdy = 0;
        cycle(1'b0, 1'b0, 10'h200, 1'b1, 1'b1, 1'b0);
        run_gate(6, 2, 2, 1'b0);
        repeat (4) cycle(1'b1, 1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0);
        #2 RESET_N = 0;
        DEMOD_ON = 0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_i", out_i, 0);
        check("mid_rst_count", out_count, 0);
        check("mid_rst_pri", out_pri, 0);
        check("mid_rst_s_q", s_q, 0);
        samp.delete();
        in_gate = 0; m_rx_d = 0; m_dm_d = 0; m_pri = 0;
        e_valid = 0; e_ovr = 0; e_sat = 0; e_sat12 = 0;
        e_i = 0; e_q = 0; e_cnt = 0; e_pri = 0; e_i12 = 0; e_q12 = 0;
        RX_CLK = 0;
        @(negedge coreClock);
        @(negedge coreClock);
        RESET_N = 1;
        repeat (3) cycle(1'b0, 1'b0, 10'h200, 1'b1, 1'b0, 1'b0);

        // Randomized gates.
        for (int g = 0; g < 40; g++) begin
            int lead, len, tail;
            logic en;
            freq = 2'($urandom_range(0, 2));
            lead = $urandom_range(1, 6);
            len  = $urandom_range(1, 60);
            tail = $urandom_range(1, 4);
            for (int c = 0; c < lead + len + tail; c++) begin
                en = ($urandom_range(0, 39) != 0);
                cycle(1'($urandom), (c >= lead) && (c < lead + len),
                      10'($urandom_range(0, 1023)), en,
                      ($urandom_range(0, 9) == 0), 1'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
